// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Provides default geometry and the occupancy-counter width function.
// No logic; imported by sync_fifo and sync_fifo_mem.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // The occupancy counter must represent 0..DEPTH inclusive, so it needs
    // one bit more than the pointers.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage array with one write port and one registered read port.
// Latency: write lands on the clock edge; read data appears one edge after rd_en.
// Backpressure: none here; the caller only issues accepted reads and writes.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset (clears the read register only)
//   wr_en    write strobe, already qualified by the caller
//   wr_addr  write address
//   wr_data  write word
//   rd_en    read strobe, already qualified by the caller
//   rd_addr  read address
//   rd_data  registered read word; holds its value when rd_en is low
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reading the pre-edge array contents means a same-address read and
    // write (FIFO full, both sides active) returns the old, oldest word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO between a producer and a consumer in one clock domain.
// Latency: rd_data/rd_valid register one edge after an accepted rd_en.
// Backpressure: full blocks writes unless a read frees a slot that cycle; empty blocks reads.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   wr_data   word to enqueue
//   wr_en     write request
//   rd_en     read request
//   full      FIFO holds DEPTH entries (registered)
//   empty     FIFO holds 0 entries (registered)
//   rd_data   registered dequeued word
//   rd_valid  one-cycle pulse qualifying rd_data
//   overflow  sticky: a write was dropped      (only with SYNC_FIFO_STATUS_EN)
//   underflow sticky: a read hit an empty FIFO (only with SYNC_FIFO_STATUS_EN)
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = count_width(DEPTH);

    // Natural pointer wrap relies on a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] wr_ptr_d,   wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d,   rd_ptr_q;
    logic [CNT_W-1:0]  count_d,    count_q;
    logic              full_d,     full_q;
    logic              empty_d,    empty_q;
    logic              rd_valid_d, rd_valid_q;
    logic              wr_acc;
    logic              rd_acc;

    always_comb begin
        // Acceptance depends only on registered flags, so wr_data X can
        // never reach the flags and there is no comb path to full/empty.
        rd_acc     = rd_en & ~empty_q;
        wr_acc     = wr_en & (~full_q | rd_acc);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags are decoded from the next count and registered alongside it.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Writes are suppressed during reset so the reset cycle's inputs are
    // fully ignored; read register reset is handled inside the memory.
    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc & rst),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_acc & rst),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign full     = full_q;
    assign empty    = empty_q;
    assign rd_valid = rd_valid_q;

`ifdef SYNC_FIFO_STATUS_EN
    logic overflow_d,  overflow_q;
    logic underflow_d, underflow_q;

    // Sticky error flags; only reset clears them.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full_q & ~rd_acc);
        underflow_d = underflow_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed scenarios followed by random traffic.
// A queue-based reference model predicts each edge; a negedge monitor checks outputs.
// Expected read words are pushed to a scoreboard queue and popped on rd_valid.
module tb_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`ifdef SYNC_FIFO_STATUS_EN
    logic              overflow;
    logic              underflow;
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .full     (full),
        .empty    (empty),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] model_q [$];  // words currently stored
    logic [DATA_W-1:0] exp_q   [$];  // words due on rd_data
    bit                exp_vld = 1'b0;
    logic [DATA_W-1:0] last_data = '0;
    bit                exp_ovf = 1'b0;
    bit                exp_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluates the same inputs the DUT sees on each rising edge.
    always @(posedge clk) begin
        int  sz;
        bit  ra;
        bit  wa;
        sz = model_q.size();
        if (rst !== 1'b1) begin
            model_q.delete();
            exp_q.delete();
            exp_vld   = 1'b0;
            last_data = '0;
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
        end else begin
            ra = rd_en && (sz > 0);
            wa = wr_en && ((sz < DEPTH) || ra);
            exp_vld = ra;
            if (wr_en && sz == DEPTH && !ra) exp_ovf = 1'b1;
            if (rd_en && sz == 0)            exp_udf = 1'b1;
            if (ra) exp_q.push_back(model_q.pop_front());
            if (wa) model_q.push_back(wr_data);
        end
    end

    // Monitor: samples away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
            chk("full",  {31'b0, full},  {31'b0, model_q.size() == DEPTH});
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_vld});
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rd_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    last_data = exp_q.pop_front();
                    chk("rd_data", {24'b0, rd_data}, {24'b0, last_data});
                end
            end else begin
                chk("rd_data_hold", {24'b0, rd_data}, {24'b0, last_data});
            end
`ifdef SYNC_FIFO_STATUS_EN
            chk("overflow",  {31'b0, overflow},  {31'b0, exp_ovf});
            chk("underflow", {31'b0, underflow}, {31'b0, exp_udf});
`endif
        end
    end

    // Drive one cycle of inputs, then advance to just after the next edge.
    // run=0 asserts reset for that edge.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic run);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rst     = run;
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; rst = 1'b0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);          // second reset cycle
        step(1'b0, '0, 1'b0, 1'b1);

        // Fill 0x01..0x10, one dropped write, drain.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reads while empty.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);

        // Simultaneous access at full, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'hA0 + i), 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Wrap-around with interleaved single writes and reads.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b1);
            else            step(1'b0, '0, 1'b1, 1'b1);
        end
        step(1'b0, '0, 1'b0, 1'b1);

        // Mid-operation reset with active inputs during the reset edge.
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with varying fill bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 250) % 3;   // 0: write-heavy, 1: balanced, 2: read-heavy
            step(($urandom_range(0, 99) < (bias == 0 ? 75 : (bias == 1 ? 50 : 25))),
                 DATA_W'($urandom),
                 ($urandom_range(0, 99) < (bias == 0 ? 25 : (bias == 1 ? 50 : 75))),
                 ($urandom_range(0, 299) != 0));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checking = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
